lut_ram_wr_arbiter: RTL and testbench

- Owns the single write port of the LUT RAM (one write port, one read port; LUT_WIDTH x LUT_DEPTH) and shares it between two write requesters with round-robin arbitration.
- Contains a clear sequencer that zero-fills every RAM entry after reset (optional) and on request.
- Sits directly in front of the RAM write port. The read port bypasses this block.

---
 rtl/lut_ram_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_lut_ram_wr_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_ram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lut_ram_wr_arbiter
//  Description : Owns the single LUT RAM write port. Shares it between two
//                requesters with round-robin arbitration and zero-fills the
//                whole RAM after reset (optional) and on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module lut_ram_wr_arbiter #(
   parameter  int LUT_WIDTH      = 32,
   parameter  int LUT_DEPTH      = 256,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int ADDR_W         = $clog2(LUT_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_req,
   input  logic                 req0,
   input  logic [ADDR_W-1:0]    req0_addr,
   input  logic [LUT_WIDTH-1:0] req0_data,
   output logic                 gnt0,
   input  logic                 req1,
   input  logic [ADDR_W-1:0]    req1_addr,
   input  logic [LUT_WIDTH-1:0] req1_data,
   output logic                 gnt1,
   output logic                 busy,
   output logic                 clear_done,
   output logic                 wr_en,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [LUT_WIDTH-1:0] wr_data
);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   // Terminal fill address; the counter is compared against it so it never
   // wraps into a second pass.
   localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(LUT_DEPTH - 1);

   state_t                 state_q;
   logic [ADDR_W-1:0]      cnt_q;
   logic                   last_q;
   logic                   wr_en_q;
   logic [ADDR_W-1:0]      wr_addr_q;
   logic [LUT_WIDTH-1:0]   wr_data_q;
   logic                   clear_done_q;

   // Round-robin grant: only in IDLE, never while a clear is being requested,
   // and when both request the one that did not win last time goes first.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst && (state_q == S_IDLE) && !clear_req) begin
         if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
      end
   end

   // Control FSM with registered write-port outputs and clear sequencing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
         cnt_q        <= '0;
         last_q       <= 1'b1;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         clear_done_q <= 1'b0;
      end else begin
         clear_done_q <= 1'b0;
         case (state_q)
            S_CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= cnt_q;
               wr_data_q <= '0;
               if (cnt_q == C_LAST_ADDR) begin
                  state_q      <= S_IDLE;
                  clear_done_q <= 1'b1;
                  cnt_q        <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               if (clear_req) begin
                  state_q <= S_CLEAR;
                  cnt_q   <= '0;
                  wr_en_q <= 1'b0;
               end else if (gnt0) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= req0_addr;
                  wr_data_q <= req0_data;
                  last_q    <= 1'b0;
               end else if (gnt1) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= req1_addr;
                  wr_data_q <= req1_data;
                  last_q    <= 1'b1;
               end else begin
                  // Address and data hold; only the enable drops.
                  wr_en_q <= 1'b0;
               end
            end
         endcase
      end
   end

   assign busy       = (state_q == S_CLEAR);
   assign clear_done = clear_done_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_ram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lut_ram_wr_arbiter
//  Description : Directed self-checking bench for lut_ram_wr_arbiter
//                (LUT_DEPTH=8; one instance clears on reset, one does not).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_ram_wr_arbiter;

   localparam int LUT_WIDTH = 32;
   localparam int LUT_DEPTH = 8;
   localparam int ADDR_W    = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clear_req;
   logic                 req0, req1;
   logic [ADDR_W-1:0]    req0_addr, req1_addr;
   logic [LUT_WIDTH-1:0] req0_data, req1_data;

   logic                 gnt0, gnt1, busy, clear_done, wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [LUT_WIDTH-1:0] wr_data;

   logic                 nc_gnt0, nc_gnt1, nc_busy, nc_clear_done, nc_wr_en;
   logic [ADDR_W-1:0]    nc_wr_addr;
   logic [LUT_WIDTH-1:0] nc_wr_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lut_ram_wr_arbiter #(.LUT_WIDTH(LUT_WIDTH), .LUT_DEPTH(LUT_DEPTH), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .rst(rst), .clear_req(clear_req),
      .req0(req0), .req0_addr(req0_addr), .req0_data(req0_data), .gnt0(gnt0),
      .req1(req1), .req1_addr(req1_addr), .req1_data(req1_data), .gnt1(gnt1),
      .busy(busy), .clear_done(clear_done),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   lut_ram_wr_arbiter #(.LUT_WIDTH(LUT_WIDTH), .LUT_DEPTH(LUT_DEPTH), .CLEAR_ON_RESET(0)) dut_nc (
      .clk(clk), .rst(rst), .clear_req(clear_req),
      .req0(req0), .req0_addr(req0_addr), .req0_data(req0_data), .gnt0(nc_gnt0),
      .req1(req1), .req1_addr(req1_addr), .req1_data(req1_data), .gnt1(nc_gnt1),
      .busy(nc_busy), .clear_done(nc_clear_done),
      .wr_en(nc_wr_en), .wr_addr(nc_wr_addr), .wr_data(nc_wr_data)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Fill of all 8 addresses: busy/no grants before each edge, zero write after.
   task automatic run_fill(input string tag);
      for (int i = 0; i < LUT_DEPTH; i++) begin
         checks++;
         if ({busy, gnt0, gnt1} !== 3'b100) begin
            errors++;
            $display("FAIL %s_busy_nogrant[%0d]: got busy,gnt0,gnt1=%b expected 100", tag, i, {busy, gnt0, gnt1});
         end
         tick();
         checks++;
         if ({wr_en, wr_addr, wr_data, clear_done} !== {1'b1, 3'(i), 32'h0, (i == LUT_DEPTH - 1)}) begin
            errors++;
            $display("FAIL %s_write[%0d]: got en=%b addr=%0d data=%h done=%b expected en=1 addr=%0d data=0 done=%b",
                     tag, i, wr_en, wr_addr, wr_data, clear_done, i, (i == LUT_DEPTH - 1));
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_end: got busy=%b expected 0", tag, busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; clear_req = 1'b0;
      req0 = 1'b1; req0_addr = 3'd1; req0_data = 32'h1111_1111;
      req1 = 1'b0; req1_addr = 3'd0; req1_data = 32'h0;
      repeat (2) tick();
      checks++;
      if ({wr_en, wr_addr, wr_data, clear_done, gnt0, gnt1, busy} !== {1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_values: got en=%b addr=%0d data=%h done=%b gnt=%b%b busy=%b expected en=0 addr=0 data=0 done=0 gnt=00 busy=1",
                  wr_en, wr_addr, wr_data, clear_done, gnt0, gnt1, busy);
      end
      checks++;
      if ({nc_busy, nc_gnt0, nc_wr_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_nc: got busy,gnt0,wr_en=%b expected 000", {nc_busy, nc_gnt0, nc_wr_en});
      end
      rst = 1'b0;
      run_fill("reset_fill");
      req0 = 1'b0;
      tick();
      checks++;
      if ({wr_en, clear_done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL post_fill_idle: got en,done,busy=%b expected 000", {wr_en, clear_done, busy});
      end
   endtask

   task automatic test_back_to_back;
      logic exp0;
      req0 = 1'b1; req0_addr = 3'd2; req0_data = 32'hA0A0_A0A0;
      req1 = 1'b1; req1_addr = 3'd6; req1_data = 32'hB1B1_B1B1;
      for (int i = 0; i < 4; i++) begin
         exp0 = (i % 2 == 0);
         #1;
         checks++;
         if ({gnt0, gnt1} !== {exp0, ~exp0}) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: got gnt0,gnt1=%b%b expected %b%b", i, gnt0, gnt1, exp0, ~exp0);
         end
         tick();
         checks++;
         if ({wr_en, wr_addr, wr_data} !== (exp0 ? {1'b1, 3'd2, 32'hA0A0_A0A0} : {1'b1, 3'd6, 32'hB1B1_B1B1})) begin
            errors++;
            $display("FAIL b2b_write[%0d]: got en=%b addr=%0d data=%h expected requester %0d", i, wr_en, wr_addr, wr_data, exp0 ? 0 : 1);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
   endtask

   task automatic test_single;
      req0 = 1'b1; req0_addr = 3'd5; req0_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++;
         $display("FAIL single_grant: got gnt0,gnt1=%b%b expected 10", gnt0, gnt1);
      end
      tick();
      req0 = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd5, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL single_write: got en=%b addr=%0d data=%h expected en=1 addr=5 data=deadbeef", wr_en, wr_addr, wr_data);
      end
      tick();
      checks++;
      if ({wr_en, wr_addr, wr_data} !== {1'b0, 3'd5, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL single_idle_hold: got en=%b addr=%0d data=%h expected en=0 addr=5 data=deadbeef", wr_en, wr_addr, wr_data);
      end
   endtask

   task automatic test_clear_req;
      clear_req = 1'b1;
      req1 = 1'b1; req1_addr = 3'd3; req1_data = 32'h0000_1234;
      #1;
      checks++;
      if ({gnt0, gnt1, busy} !== 3'b000) begin
         errors++;
         $display("FAIL clrreq_nogrant: got gnt0,gnt1,busy=%b expected 000", {gnt0, gnt1, busy});
      end
      tick();
      clear_req = 1'b0;
      checks++;
      if ({busy, wr_en} !== 2'b10) begin
         errors++;
         $display("FAIL clrreq_enter: got busy,wr_en=%b expected 10", {busy, wr_en});
      end
      for (int i = 0; i < LUT_DEPTH; i++) begin
         clear_req = (i == 3);
         #1;
         checks++;
         if ({busy, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL clrreq_fill_busy[%0d]: got busy,gnt1=%b expected 10", i, {busy, gnt1});
         end
         tick();
         clear_req = 1'b0;
         checks++;
         if ({wr_en, wr_addr, wr_data, clear_done} !== {1'b1, 3'(i), 32'h0, (i == LUT_DEPTH - 1)}) begin
            errors++;
            $display("FAIL clrreq_write[%0d]: got en=%b addr=%0d data=%h done=%b", i, wr_en, wr_addr, wr_data, clear_done);
         end
      end
      checks++;
      if ({busy, gnt1} !== 2'b01) begin
         errors++;
         $display("FAIL clrreq_after: got busy,gnt1=%b expected 01", {busy, gnt1});
      end
      tick();
      req1 = 1'b0;
      checks++;
      if ({wr_en, wr_addr, wr_data, clear_done} !== {1'b1, 3'd3, 32'h0000_1234, 1'b0}) begin
         errors++;
         $display("FAIL clrreq_req1_write: got en=%b addr=%0d data=%h done=%b expected en=1 addr=3 data=1234 done=0",
                  wr_en, wr_addr, wr_data, clear_done);
      end
      tick();
   endtask

   task automatic test_async_reset;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (4) tick();
      checks++;
      if ({busy, wr_en, wr_addr} !== {1'b1, 1'b1, 3'd3}) begin
         errors++;
         $display("FAIL arst_pre: got busy=%b en=%b addr=%0d expected busy=1 en=1 addr=3", busy, wr_en, wr_addr);
      end
      #2;
      rst = 1'b1;
      req1 = 1'b1; req1_addr = 3'd4; req1_data = 32'h0000_0055;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, clear_done, gnt1} !== {1'b0, 3'd0, 32'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL arst_immediate: got en=%b addr=%0d data=%h done=%b gnt1=%b expected all zero",
                  wr_en, wr_addr, wr_data, clear_done, gnt1);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({nc_busy, nc_gnt1, gnt1} !== 3'b010) begin
         errors++;
         $display("FAIL nc_first_grant: got nc_busy,nc_gnt1,gnt1=%b expected 010", {nc_busy, nc_gnt1, gnt1});
      end
      run_fill("arst_fill");
      req1 = 1'b0;
      checks++;
      if ({nc_wr_en, nc_wr_addr, nc_wr_data} !== {1'b1, 3'd4, 32'h0000_0055}) begin
         errors++;
         $display("FAIL nc_write: got en=%b addr=%0d data=%h expected en=1 addr=4 data=55", nc_wr_en, nc_wr_addr, nc_wr_data);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_single();
      test_clear_req();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
